// File: rtl/prog_loader.sv
// Byte-serial boot loader: parses framed records from a byte stream into IM/DM word writes
// and holds the CPU in reset until an end-of-load record is seen.
module prog_loader #(
  parameter int IM_DEPTH = 256,
  parameter int DM_DEPTH = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        im_we_o,
  output logic        dm_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] words_o
);

  typedef enum logic [3:0] {
    S_HDR,
    S_AH,
    S_AL,
    S_CH,
    S_CL,
    S_DAT,
    S_WR,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] IM_LIMIT = 17'(IM_DEPTH);
  localparam logic [16:0] DM_LIMIT = 17'(DM_DEPTH);

  localparam logic [7:0] HDR_IM   = 8'h00;
  localparam logic [7:0] HDR_DM   = 8'h01;
  localparam logic [7:0] HDR_DONE = 8'hFF;

  state_t      state_q, state_d;
  logic        tgt_dm_q;
  logic [15:0] addr_q;
  logic [15:0] rem_q;
  logic [1:0]  bcnt_q;
  logic [23:0] shf_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_q;
  logic [15:0] words_q;

  logic        accept;
  logic [15:0] count_w;
  logic [16:0] range_end;
  logic [16:0] range_limit;
  logic        last_byte;

  assign accept      = byte_valid_i && byte_ready_o;
  assign count_w     = {rem_q[15:8], byte_data_i};
  assign range_end   = {1'b0, addr_q} + {1'b0, count_w};
  assign range_limit = tgt_dm_q ? DM_LIMIT : IM_LIMIT;
  assign last_byte   = (bcnt_q == 2'd3);

  // Ready depends on state only so a source may hold valid across busy cycles.
  always_comb begin
    byte_ready_o = 1'b0;
    case (state_q)
      S_HDR, S_AH, S_AL, S_CH, S_CL, S_DAT: byte_ready_o = 1'b1;
      default:                              byte_ready_o = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR: begin
        if (accept) begin
          if (byte_data_i == HDR_IM || byte_data_i == HDR_DM) state_d = S_AH;
          else if (byte_data_i == HDR_DONE)                   state_d = S_DONE;
          else                                                state_d = S_ERR;
        end
      end
      S_AH: if (accept) state_d = S_AL;
      S_AL: if (accept) state_d = S_CH;
      S_CH: if (accept) state_d = S_CL;
      S_CL: begin
        if (accept) begin
          if (count_w == 16'd0)              state_d = S_HDR;
          else if (range_end > range_limit)  state_d = S_ERR;
          else                               state_d = S_DAT;
        end
      end
      S_DAT: if (accept && last_byte) state_d = S_WR;
      S_WR:  state_d = (rem_q == 16'd1) ? S_HDR : S_DAT;
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_HDR;
      bcnt_q  <= 2'd0;
      words_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DAT && accept)
        bcnt_q <= bcnt_q + 2'd1;
      if (state_q == S_WR)
        words_q <= words_q + 16'd1;
    end
  end

  // Write port registers: captured on the 4th data byte, held until the next word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_addr_q <= 32'd0;
      mem_data_q <= 32'd0;
    end else if (state_q == S_DAT && accept && last_byte) begin
      mem_addr_q <= {14'd0, addr_q, 2'b00};
      mem_data_q <= {shf_q, byte_data_i};
    end
  end

  // Record fields and byte assembly; a reset returns to HDR, which reloads all of these.
  always_ff @(posedge clk_i) begin
    case (state_q)
      S_HDR: if (accept) tgt_dm_q <= (byte_data_i == HDR_DM);
      S_AH:  if (accept) addr_q[15:8] <= byte_data_i;
      S_AL:  if (accept) addr_q[7:0]  <= byte_data_i;
      S_CH:  if (accept) rem_q[15:8]  <= byte_data_i;
      S_CL:  if (accept) rem_q[7:0]   <= byte_data_i;
      S_DAT: if (accept) shf_q <= {shf_q[15:0], byte_data_i};
      S_WR: begin
        addr_q <= addr_q + 16'd1;
        rem_q  <= rem_q - 16'd1;
      end
      default: ;
    endcase
  end

  assign im_we_o    = (state_q == S_WR) && !tgt_dm_q;
  assign dm_we_o    = (state_q == S_WR) &&  tgt_dm_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign done_o     = (state_q == S_DONE);
  assign err_o      = (state_q == S_ERR);
  assign cpu_rst_o  = (state_q == S_DONE);
  assign words_o    = words_q;

endmodule
